// File: rtl/row_dispatcher.sv
// row_dispatcher
//   Hands out the rows of one frame to an array of row solvers. Solvers ask
//   for work on start_request. The block answers with a one-cycle, one-hot
//   start_grant, chosen round-robin. In that same cycle it drives the shared
//   row broadcast bus. When every solver has come back idle after the last
//   row, it pulses frame_done.
//
// Ports
//   solver_clk      : block clock
//   reset_n         : asynchronous active-low reset
//   frame_start     : one-cycle frame start pulse (only accepted while idle)
//   x_reference     : left-edge real coordinate, latched at frame_start
//   x_step          : per-column real increment, latched at frame_start
//   y_top           : imaginary coordinate of row 0, latched at frame_start
//   y_step          : signed per-row imaginary increment, latched at frame_start
//   start_request   : per-solver "idle, give me a row" request
//   start_grant     : one-hot grant, high for a single cycle
//   row_x_reference : broadcast x reference (valid with a grant)
//   row_x_step      : broadcast x step (valid with a grant)
//   row_y           : broadcast y = y_top + row_y_idx*y_step (mod 2^FP_W)
//   row_y_idx       : broadcast row index
//   busy            : frame in progress
//   frame_done      : one-cycle frame completion pulse
module row_dispatcher #(
  parameter int NUM_SOLVERS = 4,
  parameter int NUM_ROWS    = 480,
  parameter int FP_W        = 27
) (
  input  logic                   solver_clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic [FP_W-1:0]        x_reference,
  input  logic [FP_W-1:0]        x_step,
  input  logic [FP_W-1:0]        y_top,
  input  logic [FP_W-1:0]        y_step,
  input  logic [NUM_SOLVERS-1:0] start_request,
  output logic [NUM_SOLVERS-1:0] start_grant,
  output logic [FP_W-1:0]        row_x_reference,
  output logic [FP_W-1:0]        row_x_step,
  output logic [FP_W-1:0]        row_y,
  output logic [8:0]             row_y_idx,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int         PTR_W    = $clog2(NUM_SOLVERS);
  localparam logic [8:0] LAST_ROW = 9'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

  state_t                   state_reg, state_next;
  logic [FP_W-1:0]          x_ref_lat_reg, x_step_lat_reg, y_step_lat_reg;
  logic [FP_W-1:0]          next_y_reg;
  logic [8:0]               row_cnt_reg;
  logic [PTR_W-1:0]         rr_ptr_reg;
  logic [NUM_SOLVERS-1:0]   pending_reg, pending_next;

  logic [NUM_SOLVERS-1:0]   eligible;
  logic [PTR_W-1:0]         winner;
  logic                     win_valid;
  logic [PTR_W:0]           scan_idx;
  logic                     all_idle;

  logic                     latch_frame, grant_fire, finish_frame;
  logic [NUM_SOLVERS-1:0]   grant_next;

  // Round-robin pick. The scan runs from the farthest offset back to
  // rr_ptr itself. That way the closest eligible index at or after the
  // pointer overwrites any earlier candidate and wins.
  always_comb begin
    eligible  = start_request & ~pending_reg;
    winner    = '0;
    win_valid = 1'b0;
    scan_idx  = '0;
    for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
      if (scan_idx >= (PTR_W + 1)'(NUM_SOLVERS))
        scan_idx = scan_idx - (PTR_W + 1)'(NUM_SOLVERS);
      if (eligible[scan_idx[PTR_W-1:0]]) begin
        winner    = scan_idx[PTR_W-1:0];
        win_valid = 1'b1;
      end
    end
  end

  // A solver that never took a row has pending=0 and request=1, so it
  // already counts as idle here.
  assign all_idle = &(start_request & ~pending_reg);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge solver_clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (frame_start) state_next = DISPATCH;
      DISPATCH: if (win_valid && row_cnt_reg == LAST_ROW) state_next = DRAIN;
      DRAIN:    if (all_idle) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    latch_frame  = (state_reg == IDLE) && frame_start;
    grant_fire   = (state_reg == DISPATCH) && win_valid;
    finish_frame = (state_reg == DRAIN) && all_idle;
    grant_next   = grant_fire ? (NUM_SOLVERS'(1) << winner) : '0;
  end

  // A solver's request drop is registered, so its request is still high on
  // the cycle after its grant. The pending bit masks it until its request
  // is seen low.
  for (genvar gi = 0; gi < NUM_SOLVERS; gi++) begin : g_pending
    assign pending_next[gi] = grant_next[gi] | (pending_reg[gi] & start_request[gi]);
  end

  always_ff @(posedge solver_clk or negedge reset_n) begin
    if (!reset_n) pending_reg <= '0;
    else          pending_reg <= pending_next;
  end

  // ---------------- Frame datapath and broadcast registers ----------------
  always_ff @(posedge solver_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_ref_lat_reg   <= '0;
      x_step_lat_reg  <= '0;
      y_step_lat_reg  <= '0;
      next_y_reg      <= '0;
      row_cnt_reg     <= '0;
      rr_ptr_reg      <= '0;
      start_grant     <= '0;
      row_x_reference <= '0;
      row_x_step      <= '0;
      row_y           <= '0;
      row_y_idx       <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      start_grant <= grant_next;
      frame_done  <= finish_frame;

      if (latch_frame) begin
        x_ref_lat_reg  <= x_reference;
        x_step_lat_reg <= x_step;
        y_step_lat_reg <= y_step;
        next_y_reg     <= y_top;
        row_cnt_reg    <= '0;
        busy           <= 1'b1;
      end

      if (grant_fire) begin
        row_y_idx       <= row_cnt_reg;
        row_y           <= next_y_reg;
        row_x_reference <= x_ref_lat_reg;
        row_x_step      <= x_step_lat_reg;
        next_y_reg      <= next_y_reg + y_step_lat_reg;
        row_cnt_reg     <= row_cnt_reg + 9'd1;
        rr_ptr_reg      <= (winner == PTR_W'(NUM_SOLVERS - 1)) ? '0 : winner + 1'b1;
      end

      if (finish_frame) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_row_dispatcher.sv
module tb_row_dispatcher;
  localparam int N   = 4;
  localparam int NR  = 480;
  localparam int FPW = 27;

  logic           solver_clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           frame_start = 1'b0;
  logic [FPW-1:0] x_reference = '0, x_step = '0, y_top = '0, y_step = '0;
  logic [N-1:0]   start_request = '0;
  logic [N-1:0]   start_grant;
  logic [FPW-1:0] row_x_reference, row_x_step, row_y;
  logic [8:0]     row_y_idx;
  logic           busy, frame_done;

  row_dispatcher #(.NUM_SOLVERS(N), .NUM_ROWS(NR), .FP_W(FPW)) dut (
    .solver_clk(solver_clk), .reset_n(reset_n), .frame_start(frame_start),
    .x_reference(x_reference), .x_step(x_step), .y_top(y_top), .y_step(y_step),
    .start_request(start_request), .start_grant(start_grant),
    .row_x_reference(row_x_reference), .row_x_step(row_x_step), .row_y(row_y),
    .row_y_idx(row_y_idx), .busy(busy), .frame_done(frame_done)
  );

  always #5 solver_clk = ~solver_clk;

  int total = 0;
  int bad = 0;

  // Reference model: frame phase, outstanding rows per solver, next row.
  int             m_phase;  // 0 idle, 1 handing out rows, 2 waiting for solvers
  bit             m_pend[N];
  int             m_rr, m_row;
  logic [FPW-1:0] m_y, m_xr, m_xs, m_ys;
  logic [N-1:0]   e_grant;
  logic [8:0]     e_idx;
  logic [FPW-1:0] e_y, e_xr, e_xs;
  logic           e_busy, e_done;

  // Solver behaviour and scoreboard
  bit             auto_mode;
  bit             s_hold[N];
  int             s_cnt[N];
  int             row_seen[NR];
  int             done_seen;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_row = 0;
    m_y = '0; m_xr = '0; m_xs = '0; m_ys = '0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    e_grant = '0; e_idx = '0; e_y = '0; e_xr = '0; e_xs = '0;
    e_busy = 1'b0; e_done = 1'b0;
  endtask

  task automatic solvers_reset();
    for (int i = 0; i < N; i++) begin
      s_hold[i] = 1'b0;
      s_cnt[i] = 0;
    end
    start_request = '1;
  endtask

  // Predict what the block shows after the coming edge, from the inputs now applied.
  task automatic model_cycle();
    bit elig[N];
    bit idle_all;
    int w;
    e_grant = '0; e_done = 1'b0; w = -1; idle_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      elig[i] = start_request[i] && !m_pend[i];
      if (!elig[i]) idle_all = 1'b0;
    end
    for (int i = 0; i < N; i++) if (!start_request[i]) m_pend[i] = 1'b0;
    case (m_phase)
      0: if (frame_start) begin
        m_xr = x_reference; m_xs = x_step; m_ys = y_step; m_y = y_top;
        m_row = 0; e_busy = 1'b1; m_phase = 1;
      end
      1: begin
        for (int k = 0; k < N; k++)
          if (w < 0 && elig[(m_rr + k) % N]) w = (m_rr + k) % N;
        if (w >= 0) begin
          e_grant = N'(1) << w;
          e_idx = 9'(m_row); e_y = m_y; e_xr = m_xr; e_xs = m_xs;
          m_y = m_y + m_ys;
          m_pend[w] = 1'b1;
          m_rr = (w + 1) % N;
          if (m_row == NR - 1) m_phase = 2;
          m_row++;
        end
      end
      default: if (idle_all) begin
        e_done = 1'b1; e_busy = 1'b0; m_phase = 0;
      end
    endcase
  endtask

  // Solver: keeps its request high one cycle past its grant, then works for 5..40 cycles.
  task automatic solver_update();
    for (int i = 0; i < N; i++) begin
      if (e_grant[i]) s_hold[i] = 1'b1;
      else if (s_hold[i]) begin
        s_hold[i] = 1'b0;
        start_request[i] = 1'b0;
        s_cnt[i] = int'($urandom_range(40, 5));
      end else if (s_cnt[i] > 0) begin
        s_cnt[i]--;
        if (s_cnt[i] == 0) start_request[i] = 1'b1;
      end
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge solver_clk);
    #1;
    frame_start = 1'b0;
    chk("grant", start_grant, e_grant);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_done);
    if (e_grant != '0) begin
      chk("row_y_idx", row_y_idx, e_idx);
      chk("row_y", row_y, e_y);
      chk("row_x_reference", row_x_reference, e_xr);
      chk("row_x_step", row_x_step, e_xs);
    end
    if (|start_grant && row_y_idx < 9'(NR)) row_seen[row_y_idx]++;
    if (frame_done) done_seen++;
    if (auto_mode) solver_update();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_grant"}, start_grant, 0);
    chk({tag, "_xref"}, row_x_reference, 0);
    chk({tag, "_xstep"}, row_x_step, 0);
    chk({tag, "_row_y"}, row_y, 0);
    chk({tag, "_idx"}, row_y_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  logic [N-1:0]   g_obs[4];
  logic [8:0]     i_obs[4];
  logic [FPW-1:0] y_obs[4];
  logic [FPW-1:0] y1, y2;
  logic [8:0]     base_idx;
  int gcap, cyc, nbad, ngr;

  initial begin
    model_reset();
    auto_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin g_obs[i] = '0; i_obs[i] = '0; y_obs[i] = '0; end

    // Reset state
    repeat (2) @(posedge solver_clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // Full frame, random solver row times, plus an ignored frame_start mid-frame
    x_reference = 27'h1234567; x_step = 27'h0000100;
    y_top = 27'h0100000; y_step = 27'h0000800;
    for (int i = 0; i < NR; i++) row_seen[i] = 0;
    done_seen = 0; gcap = 0; cyc = 0;
    solvers_reset();
    auto_mode = 1'b1;
    frame_start = 1'b1;
    while (done_seen == 0 && cyc < 20000) begin
      if (cyc == 60) begin
        frame_start = 1'b1;
        x_reference = 27'h7654321; y_top = 27'h0000003; y_step = 27'h0000005;
      end
      step();
      cyc++;
      if (|start_grant && gcap < 4) begin
        g_obs[gcap] = start_grant; i_obs[gcap] = row_y_idx; y_obs[gcap] = row_y;
        gcap++;
      end
    end
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      chk("first_grants", g_obs[k], N'(1) << k);
      chk("first_idx", i_obs[k], k);
      chk("first_row_y", y_obs[k], 27'h0100000 + 27'(k) * 27'h0000800);
    end
    nbad = 0;
    for (int i = 0; i < NR; i++) if (row_seen[i] != 1) nbad++;
    chk("rows_granted_once", nbad, 0);
    chk("frame_done_count", done_seen, 1);
    chk("busy_after_frame", busy, 0);
    $display("frame: %0d cycles, %0d rows not granted exactly once", cyc, nbad);

    // Negative y_step wraps mod 2^27; run on to row 100
    solvers_reset();
    x_reference = 27'h0ABCDEF; y_top = 27'h0; y_step = 27'h7FFF800;
    y1 = '0; y2 = '0; cyc = 0;
    frame_start = 1'b1;
    while (cyc < 5000) begin
      step();
      cyc++;
      if (|start_grant) begin
        if (row_y_idx == 9'd1) y1 = row_y;
        if (row_y_idx == 9'd2) y2 = row_y;
        if (row_y_idx == 9'd100) break;
      end
    end
    chk("neg_step_row1", y1, 27'h7FFF800);
    chk("neg_step_row2", y2, 27'h7FFF000);
    chk("reached_row_100", row_y_idx, 100);

    // Asynchronous reset mid-frame, then restart from row 0 at solver 0
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    solvers_reset();
    @(posedge solver_clk); #1;
    @(posedge solver_clk); #1;
    reset_n = 1'b1;
    frame_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (|start_grant) break;
    end
    chk("restart_grant", start_grant, 4'b0001);
    chk("restart_idx", row_y_idx, 0);
    $display("restart: grant=%b idx=%0d", start_grant, row_y_idx);

    // Single solver: no re-grant while pending, re-grant one cycle after re-raise
    reset_n = 1'b0;
    model_reset();
    auto_mode = 1'b0;
    @(posedge solver_clk); #1;
    reset_n = 1'b1;
    start_request = 4'b0100;
    frame_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (|start_grant) break;
    end
    chk("solo_first_grant", start_grant, 4'b0100);
    base_idx = row_y_idx;
    step();
    ngr = int'(|start_grant);
    start_request = 4'b0000;
    repeat (30) begin
      step();
      ngr += int'(|start_grant);
    end
    chk("solo_no_regrant", ngr, 0);
    start_request = 4'b0100;
    step();
    chk("solo_regrant", start_grant, 4'b0100);
    chk("solo_regrant_idx", row_y_idx, base_idx + 9'd1);
    $display("solo: first idx=%0d regrant idx=%0d", base_idx, row_y_idx);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
